display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (fixed at 4 in this revision).
REQ-002 Parameter: DWELL, 50000000, clock cycles a granted value is shown; legal range 1..2^32-1.
REQ-003 Port: clock  input  1  sole clock, all state on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: req  input  4  per-requester level request; bit i = requester i.
REQ-006 Port: req_val  input  128  request values, requester i at [32*i+31:32*i].
REQ-007 Port: ack  output  4  one-cycle pulse to the requester whose value was captured.
REQ-008 Port: val  output  32  value driven to the 8-digit display driver.
REQ-009 Port: val_valid  output  1  high while a granted value is being shown.
REQ-010 Port: owner  output  2  index of the current or last owner.
REQ-011 Port: done  output  1  one-cycle pulse when a dwell period completes.

Function
REQ-012 The block SHALL implement states IDLE and SHOW.
REQ-013 In IDLE with any req bit high, the block SHALL select one requester round-robin, starting from (owner+1) mod 4, and SHALL enter SHOW on the next edge.
REQ-014 On entry to SHOW, the block SHALL register val from the winner's req_val and set owner to the winner.
REQ-015 On entry to SHOW, the block SHALL assert ack[winner] for exactly that first SHOW cycle (registered; one cycle after the request was sampled).
REQ-016 In SHOW, val_valid SHALL be 1, val SHALL be stable, and a dwell counter SHALL run from 0 to DWELL-1.
REQ-017 On the cycle the counter equals DWELL-1, the block SHALL pulse done for one cycle.
REQ-018 On that same edge, if any req is high, the block SHALL arbitrate per REQ-013 and re-enter SHOW with a counter of 0, with no IDLE gap; otherwise it SHALL go to IDLE.
REQ-019 Deassertion of req during SHOW SHALL NOT shorten the dwell.
REQ-020 A requester still holding req after its ack SHALL be treated as a new request and SHALL lose to any other pending requester at the next arbitration.
REQ-021 A sole pending requester SHALL be regranted back-to-back.
REQ-022 In IDLE, val SHALL hold the last shown value, val_valid SHALL be 0, and owner SHALL hold.
REQ-023 Changes on req_val after capture SHALL NOT affect val.
REQ-024 With DWELL=1, each SHOW SHALL last exactly one cycle and done SHALL pulse every SHOW cycle.

Reset
REQ-025 While reset_n is low, the block SHALL force state=IDLE, val=0, val_valid=0, owner=3 (so requester 0 wins first), ack=0, done=0, and counter=0, independent of clock.
REQ-026 Reset asserted mid-SHOW SHALL abandon the dwell with no done pulse.
REQ-027 After reset_n deasserts, the block SHALL sample req at the first rising edge.

Configuration
REQ-028 Macro DISPLAY_ARBITER_PREEMPT_EN: when defined, req[0] high during SHOW with owner!=0 SHALL abort the dwell (no done pulse) and grant requester 0 on the next edge per REQ-014/REQ-015.
REQ-029 When DISPLAY_ARBITER_PREEMPT_EN is not defined, requester 0 SHALL have no priority beyond round-robin.

Structure
REQ-030 Package display_arbiter_pkg SHALL hold the state enum, NREQ, and the 2-bit requester-id typedef.
REQ-031 Round-robin selection SHALL be a combinational sub-module disp_rr_pick with inputs req[3:0] and last[1:0], and outputs any and winner[1:0].

Verification (DWELL=4 unless stated)
REQ-032 Reset, then req=4'b0001 with req_val[31:0]=32'h12345678 -> ack=4'b0001 one cycle later; val=32'h12345678 and val_valid=1 for 4 cycles; done pulses on the 4th; then IDLE.
REQ-033 req=4'b1111 held -> owners 0,1,2,3,0 in successive 4-cycle windows; no val_valid gap.
REQ-034 req_val[0] changed to 32'hDEADBEEF mid-dwell -> val stays 32'h12345678 until the next grant.
REQ-035 reset_n pulsed low at dwell cycle 2 -> val=0, val_valid=0 immediately (asynchronous); no done pulse.
REQ-036 With DISPLAY_ARBITER_PREEMPT_EN defined, owner=2 at dwell cycle 1 and req[0] rises -> next cycle owner=0, ack=4'b0001, no done pulse for requester 2.
REQ-037 DWELL=1 with req=4'b0110 -> owner alternates 1,2 every cycle; done is high continuously.

Source files
------------

// File: rtl/display_arbiter_pkg.sv
// display_arbiter_pkg: shared types and constants for the display arbiter.
// Holds the FSM state enum, the requester count and the 2-bit requester id.
package display_arbiter_pkg;

  localparam int NREQ = 4;

  typedef logic [1:0] req_id_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // One-hot acknowledge vector for a requester id.
  function automatic logic [NREQ-1:0] id_onehot(input req_id_t id);
    return NREQ'(1) << id;
  endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// disp_rr_pick: combinational round-robin pick over four requesters.
// The search starts at (last+1) mod 4 and wraps, so 'last' itself is
// considered only after every other requester.
module disp_rr_pick
  import display_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_id_t         last,
  output logic            any,
  output req_id_t         winner
);

  // First set request bit found walking upward from last+1.
  always_comb begin
    logic    found;
    req_id_t idx;
    any    = |req;
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + req_id_t'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: grants one of four requesters the 8-digit display for a
// dwell of DWELL cycles, choosing round-robin after the previous owner.
// Optional feature macro: DISPLAY_ARBITER_PREEMPT_EN -- when defined,
// requester 0 aborts another owner's dwell and is granted immediately.
// Handshake: req is a level; the winner sees ack for exactly the first
// SHOW cycle (one edge after its req was sampled) and should drop req
// then if it has nothing more to show.
module display_arbiter #(
  parameter int          NREQ  = 4,
  parameter int unsigned DWELL = 50000000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_val,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          val,
  output logic                 val_valid,
  output logic [1:0]           owner,
  output logic                 done
);

  import display_arbiter_pkg::*;

  localparam logic [31:0] LAST_CNT = 32'(DWELL - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_cnt;
  logic [31:0]     w_cnt_nxt;
  logic [31:0]     r_val;
  req_id_t         r_owner;
  logic [NREQ-1:0] r_ack;

  logic            w_any;
  req_id_t         w_winner;
  logic            w_grant;
  req_id_t         w_grant_id;
  logic            w_last;
  logic [31:0]     w_sel_val;

  disp_rr_pick u_pick (
    .req    (req),
    .last   (r_owner),
    .any    (w_any),
    .winner (w_winner)
  );

  assign w_last    = (r_cnt == LAST_CNT);
  assign w_sel_val = req_val[{w_grant_id, 5'd0} +: 32];

  // Next-state, dwell counter and grant decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_grant_id  = w_winner;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
`ifdef DISPLAY_ARBITER_PREEMPT_EN
        if (req[0] && (r_owner != req_id_t'(0))) begin
          // Requester 0 cuts the current dwell short; no done pulse.
          w_grant    = 1'b1;
          w_grant_id = req_id_t'(0);
          w_cnt_nxt  = '0;
        end else
`endif
        if (w_last) begin
          w_cnt_nxt = '0;
          if (w_any) begin
            w_grant = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dwell counter, captured value, owner and registered ack pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_val   <= '0;
      r_owner <= req_id_t'(NREQ - 1);
      r_ack   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ack <= w_grant ? id_onehot(w_grant_id) : '0;
      if (w_grant) begin
        r_val   <= w_sel_val;
        r_owner <= w_grant_id;
      end
    end
  end

  assign ack       = r_ack;
  assign val       = r_val;
  assign owner     = r_owner;
  assign val_valid = (r_state == ST_SHOW);
  assign done      = (r_state == ST_SHOW) && w_last;

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed bench for display_arbiter with DWELL=4
// (main instance) and DWELL=1 (second instance).
module tb_display_arbiter;

  logic          clock;
  logic          reset_n;
  logic [3:0]    req;
  logic [3:0]    req1;
  logic [127:0]  req_val;
  logic [3:0]    ack,  ack1;
  logic [31:0]   val,  val1;
  logic          val_valid, val_valid1;
  logic [1:0]    owner, owner1;
  logic          done, done1;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  display_arbiter #(.NREQ(4), .DWELL(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_val   (req_val),
    .ack       (ack),
    .val       (val),
    .val_valid (val_valid),
    .owner     (owner),
    .done      (done)
  );

  display_arbiter #(.NREQ(4), .DWELL(1)) dut1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req1),
    .req_val   (req_val),
    .ack       (ack1),
    .val       (val1),
    .val_valid (val_valid1),
    .owner     (owner1),
    .done      (done1)
  );

  // Clock and reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rv(input int id);
    return req_val[32*id +: 32];
  endfunction

  function automatic logic [3:0] oh(input int id);
    return 4'(1) << id;
  endfunction

  task automatic check_show(input string tag, input logic [3:0] ack_e, input logic [31:0] val_e,
                            input logic [1:0] owner_e, input logic done_e);
    check({tag, ".ack"},   32'(ack),       32'(ack_e));
    check({tag, ".val"},   val,            val_e);
    check({tag, ".vv"},    32'(val_valid), 32'd1);
    check({tag, ".owner"}, 32'(owner),     32'(owner_e));
    check({tag, ".done"},  32'(done),      32'(done_e));
  endtask

  task automatic check_idle(input string tag, input logic [31:0] val_e, input logic [1:0] owner_e);
    check({tag, ".ack"},   32'(ack),       32'd0);
    check({tag, ".val"},   val,            val_e);
    check({tag, ".vv"},    32'(val_valid), 32'd0);
    check({tag, ".owner"}, 32'(owner),     32'(owner_e));
    check({tag, ".done"},  32'(done),      32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    req1    = '0;
    req_val = '0;

    // Reset state.
    #12;
    check_idle("rst", 32'h0, 2'd3);
    check("rst1.done", 32'(done1), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_idle("idle0", 32'h0, 2'd3);

    // Single request, capture, mid-dwell req_val change.
    req = 4'b0001;
    req_val[31:0] = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_show($sformatf("a%0d", k), (k == 0) ? 4'b0001 : 4'b0000, 32'h1234_5678, 2'd0, k == 3);
      req = 4'b0000;
      if (k == 1) req_val[31:0] = 32'hDEAD_BEEF;
    end
    tick();
    check_idle("a_idle", 32'h1234_5678, 2'd0);
    tick();
    check_idle("a_idle2", 32'h1234_5678, 2'd0);
    req = 4'b0001;
    tick();
    check_show("a_new", 4'b0001, 32'hDEAD_BEEF, 2'd0, 1'b0);
    req = 4'b0000;
    for (int k = 1; k < 4; k++) tick();
    tick();
    check_idle("a_end", 32'hDEAD_BEEF, 2'd0);

    // Full request set rotates owners with no gap.
    reset_n = 1'b0;
    #1;
    check_idle("rst2", 32'h0, 2'd3);
    @(negedge clock);
    reset_n = 1'b1;
    req_val = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA0A0_A0A0};
    req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        check_show($sformatf("rr%0d_%0d", w, k), (k == 0) ? oh(w % 4) : 4'b0000,
                   rv(w % 4), 2'(w % 4), k == 3);
      end
    end

    // Asynchronous reset in the middle of a dwell.
    tick();
    tick();
    tick();
    check_show("pre_rst", 4'b0000, rv(1), 2'd1, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check_idle("arst", 32'h0, 2'd3);
    tick();
    check_idle("arst_h1", 32'h0, 2'd3);
    tick();
    check_idle("arst_h2", 32'h0, 2'd3);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_show("post_rst", 4'b0001, rv(0), 2'd0, 1'b0);
    req = 4'b0010;
    for (int k = 1; k < 4; k++) begin
      tick();
      check_show($sformatf("p0_%0d", k), 4'b0000, rv(0), 2'd0, k == 3);
    end
    tick();
    check_show("own1", 4'b0010, rv(1), 2'd1, 1'b0);
    for (int k = 1; k < 4; k++) tick();
    check("own1.done", 32'(done), 32'd1);
    tick();
    check_show("own1_again", 4'b0010, rv(1), 2'd1, 1'b0);
    req = 4'b1010;
    for (int k = 1; k < 4; k++) tick();
    tick();
    check_show("held_loses", 4'b1000, rv(3), 2'd3, 1'b0);
    req = 4'b0100;
    for (int k = 1; k < 4; k++) tick();
    tick();
    check_show("own2", 4'b0100, rv(2), 2'd2, 1'b0);
    tick();
    check_show("own2_c1", 4'b0000, rv(2), 2'd2, 1'b0);
    req = 4'b0101;
`ifdef DISPLAY_ARBITER_PREEMPT_EN
    tick();
    check_show("preempt", 4'b0001, rv(0), 2'd0, 1'b0);
    req = 4'b0000;
`else
    tick();
    check_show("no_preempt_c2", 4'b0000, rv(2), 2'd2, 1'b0);
    tick();
    check_show("no_preempt_c3", 4'b0000, rv(2), 2'd2, 1'b1);
    tick();
    check_show("rr_to0", 4'b0001, rv(0), 2'd0, 1'b0);
    req = 4'b0000;
`endif
    for (int k = 1; k < 4; k++) tick();
    tick();
    check_idle("b_end", rv(0), 2'd0);

    // DWELL=1 instance alternates between two requesters every cycle.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd2);
    end
    req1 = 4'b0110;
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      tick();
      e = exp_q.pop_front();
      check("d1.owner", 32'(owner1),     e);
      check("d1.ack",   32'(ack1),       32'(oh(int'(e))));
      check("d1.done",  32'(done1),      32'd1);
      check("d1.vv",    32'(val_valid1), 32'd1);
      check("d1.val",   val1,            rv(int'(e)));
    end
    req1 = 4'b0000;
    tick();
    check("d1_idle.vv",   32'(val_valid1), 32'd0);
    check("d1_idle.done", 32'(done1),      32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
